// File: rtl/serial_cmp_pkg.sv
// Shared types and defaults for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    localparam int CMP_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit magnitude comparator cell: exactly one of gt/lt/eq is high.
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);
    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial unsigned magnitude comparator, one bit pair per cycle, MSB first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_cmp
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less_than,
    output logic             equal_to,
    output logic             greater_than,
    output logic             busy
);
    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    cmp_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IDX_W-1:0] idx;
    logic             decided, gt_r, lt_r;
    logic             bit_gt, bit_lt, bit_eq;
    logic             accept, release_w, last_bit, first_diff;

    comparator_1bit u_bit (
        .a  (a_r[idx]),
        .b  (b_r[idx]),
        .gt (bit_gt),
        .lt (bit_lt),
        .eq (bit_eq)
    );

    assign accept     = in_valid & (state == IDLE);
    assign release_w  = out_ready & (state == DONE);
    assign last_bit   = (idx == '0);
    assign first_diff = ~decided & ~bit_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = SCAN;
            SCAN: begin
                if (last_bit) state_nxt = DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (first_diff) state_nxt = DONE;
`endif
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result is latched on the first differing bit only; later bits cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            idx     <= IDX_MSB;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= IDX_MSB;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
        end else if (state == SCAN) begin
            if (first_diff) begin
                decided <= 1'b1;
                gt_r    <= bit_gt;
                lt_r    <= bit_lt;
            end
            if (!last_bit) idx <= idx - 1'b1;
        end else if (release_w) begin
            idx     <= IDX_MSB;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
        end
    end

    // Flags are gated by DONE so nothing partial is visible during SCAN.
    assign in_ready     = (state == IDLE);
    assign busy         = (state == SCAN);
    assign out_valid    = (state == DONE);
    assign greater_than = (state == DONE) & gt_r;
    assign less_than    = (state == DONE) & lt_r;
    assign equal_to     = (state == DONE) & ~decided;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Scoreboard bench for serial_mag_cmp: a WIDTH=8 and a WIDTH=1 instance.
module tb_serial_mag_cmp;

    typedef struct {
        logic [2:0] flags;   // {lt, eq, gt}
        int         lat;
        longint     acc;
        int         hold;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic       in_valid_v [2];
    logic       in_ready_v [2];
    logic       out_valid_v [2];
    logic       out_ready_v [2];
    logic       lt_v [2];
    logic       eq_v [2];
    logic       gt_v [2];
    logic       busy_v [2];

    exp_t       q0 [$];
    exp_t       q1 [$];
    longint     cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic       held [2];
    logic       hs [2];
    logic [2:0] hflags [2];
    int         hcnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_mag_cmp #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .less_than(lt_v[0]), .equal_to(eq_v[0]), .greater_than(gt_v[0]),
        .busy(busy_v[0])
    );

    serial_mag_cmp #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][0:0]), .b(b_v[1][0:0]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .less_than(lt_v[1]), .equal_to(eq_v[1]), .greater_than(gt_v[1]),
        .busy(busy_v[1])
    );

    function automatic void chk(string nm, longint act, longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Reference: plain unsigned compare; latency from the top differing bit.
    function automatic exp_t model(int i, logic [7:0] av, logic [7:0] bv, int hold);
        exp_t       e;
        int         w;
        int         msb;
        logic [7:0] am, bm, x;
        w  = (i == 0) ? 8 : 1;
        am = (i == 0) ? av : {7'd0, av[0]};
        bm = (i == 0) ? bv : {7'd0, bv[0]};
        e.flags = (am < bm) ? 3'b100 : (am == bm) ? 3'b010 : 3'b001;
        e.lat   = w;
        e.hold  = hold;
        e.acc   = 0;
        x = am ^ bm;
        msb = 0;
        for (int k = 0; k < 8; k++) if (x[k]) msb = k;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (x != 0) e.lat = w - msb;
`endif
        return e;
    endfunction

    task automatic send(int i, logic [7:0] av, logic [7:0] bv, int hold);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        a_v[i] = av;
        b_v[i] = bv;
        in_valid_v[i] = 1'b1;
        while (!in_ready_v[i] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e = model(i, av, bv, hold);
            e.acc = cyc + 1;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1 in_valid_v[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_out_valid"}, out_valid_v[i], 0);
            chk({tag, "_in_ready"}, in_ready_v[i], 1);
            chk({tag, "_busy"}, busy_v[i], 0);
            chk({tag, "_flags"}, {lt_v[i], eq_v[i], gt_v[i]}, 0);
        end
    endtask

    // Monitor/consumer: pops on the first out_valid cycle of each result.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                held[i] = 1'b0;
                hs[i] = 1'b0;
                hcnt[i] = 0;
                out_ready_v[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t       e;
                int         qs;
                logic [2:0] fl;
                logic       bexp;
                fl = {lt_v[i], eq_v[i], gt_v[i]};
                qs = (i == 0) ? q0.size() : q1.size();
                if (hs[i]) begin
                    chk("idle_after_ack", {out_valid_v[i], in_ready_v[i]}, 2'b01);
                    hs[i] = 1'b0;
                    held[i] = 1'b0;
                end
                if (out_valid_v[i]) begin
                    if (!held[i]) begin
                        if (qs == 0) begin
                            chk("unexpected_result", 1, 0);
                            hflags[i] = fl;
                            hcnt[i] = 0;
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk("flags", fl, e.flags);
                            chk("latency", cyc - e.acc, e.lat);
                            hflags[i] = e.flags;
                            hcnt[i] = e.hold;
                        end
                        held[i] = 1'b1;
                    end else begin
                        chk("flags_stable", fl, hflags[i]);
                    end
                    chk("in_ready_in_done", in_ready_v[i], 0);
                    chk("busy_in_done", busy_v[i], 0);
                    out_ready_v[i] = (hcnt[i] == 0);
                    if (hcnt[i] > 0) hcnt[i]--;
                    if (out_ready_v[i]) hs[i] = 1'b1;
                end else begin
                    held[i] = 1'b0;
                    out_ready_v[i] = 1'($urandom_range(0, 1));
                    chk("flags_not_done", fl, 0);
                    bexp = 1'b0;
                    if (qs > 0) bexp = (cyc >= ((i == 0) ? q0[0].acc : q1[0].acc));
                    chk("busy", busy_v[i], bexp);
                    chk("in_ready", in_ready_v[i], !bexp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            in_valid_v[i] = 1'b0;
        end
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 8'hA5, 8'hA5, 0);
        send(0, 8'h80, 8'h7F, 0);
        send(0, 8'h12, 8'h13, 0);
        // Result held 5 cycles while the next pair is already offered.
        send(0, 8'h5A, 8'h3C, 5);
        send(0, 8'h01, 8'h01, 0);
        send(0, 8'h00, 8'hFF, 1);
        send(0, 8'hFF, 8'h00, 0);

        send(1, 8'h01, 8'h00, 0);
        send(1, 8'h01, 8'h01, 0);
        send(1, 8'h00, 8'h01, 0);
        send(1, 8'h00, 8'h00, 2);

        for (int n = 0; n < 40; n++)
            send(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        for (int n = 0; n < 10; n++)
            send(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

        for (int t = 0; t < 200 && (q0.size() > 0 || out_valid_v[0]); t++) @(negedge clk);

        // Reset mid-operation: the pending result must vanish.
        send(0, 8'h00, 8'hFF, 20);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        q0.delete();
        q1.delete();
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_out_valid", out_valid_v[0], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 8'h33, 8'h34, 0);
        send(0, 8'hC3, 8'hC3, 0);

        for (int t = 0; t < 200 &&
             (q0.size() > 0 || q1.size() > 0 || out_valid_v[0] || out_valid_v[1]); t++)
            @(negedge clk);
        chk("drain", q0.size() + q1.size(), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_mag_cmp.md
SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operand pair a/b offered.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 The block SHALL have port a, input, WIDTH, first operand, unsigned.
REQ-007 The block SHALL have port b, input, WIDTH, second operand, unsigned.
REQ-008 The block SHALL have port out_valid, output, 1, result flags valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have ports less_than, equal_to and greater_than, each output, 1, giving a<b, a==b and a>b.
REQ-011 The block SHALL have port busy, output, 1, high while a comparison is in SCAN.

Function
REQ-012 The block SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); an accept SHALL occur on an edge with in_valid & in_ready.
REQ-014 On accept, the block SHALL register a and b, set bit index idx=WIDTH-1, clear the decided flag, and go to SCAN.
REQ-015 In SCAN, each cycle SHALL compare exactly one bit pair a_r[idx]/b_r[idx], MSB first.
REQ-016 The first bit pair with a_r[idx]!=b_r[idx] SHALL set the decided flag and latch greater_than=a_r[idx], less_than=b_r[idx]; later bits SHALL NOT change the latched result.
REQ-017 When idx==0 is compared and no difference was found, the block SHALL latch equal_to=1.
REQ-018 SCAN SHALL exit to DONE on the cycle that compares idx==0, or earlier per REQ-027; idx SHALL NOT wrap.
REQ-019 In DONE, out_valid SHALL be 1 with exactly one of less_than/equal_to/greater_than high, all flags held stable until handshake.
REQ-020 On an edge with out_valid & out_ready, the block SHALL clear all three flags and return to IDLE; the next accept SHALL be possible one cycle later.
REQ-021 in_valid SHALL be ignored and a, b SHALL be don't-care outside IDLE.
REQ-022 Outside DONE, less_than, equal_to, greater_than and out_valid SHALL be 0.
REQ-023 Latency SHALL be measured from the accept edge to the first cycle with out_valid=1: WIDTH cycles, or fewer per REQ-027.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, in_ready=1, out_valid=0, busy=0, all flags 0, and idx=WIDTH-1, asynchronously.
REQ-025 Reset asserted mid-SCAN or mid-DONE SHALL discard the operation; no partial result SHALL ever appear.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-027 With macro SERIAL_CMP_EARLY_EXIT_EN defined, SCAN SHALL exit to DONE on the cycle that finds the first differing bit (latency = WIDTH-idx), and equal operands SHALL still take WIDTH cycles.
REQ-028 Without SERIAL_CMP_EARLY_EXIT_EN, latency SHALL always be WIDTH cycles (constant-time), and the result SHALL be identical to the early-exit build.

Structure
REQ-029 Package serial_cmp_pkg SHALL hold the state enum typedef (IDLE/SCAN/DONE) and the WIDTH default constant.
REQ-030 The per-bit decision SHALL be made by one instance of the team's existing comparator_1bit cell, fed a_r[idx]/b_r[idx]; there SHALL be no other sub-module.

Verification
REQ-031 The bench SHALL cover these scenarios:
- WIDTH=8, a=0xA5, b=0xA5 -> equal_to=1 after 8 cycles in both builds.
- a=0x80, b=0x7F -> greater_than=1 after 1 cycle with EARLY_EXIT, 8 cycles without.
- a=0x12, b=0x13 -> less_than=1 after 8 cycles in both builds.
- Result ready, out_ready held 0 for 5 cycles while in_valid=1 -> flags stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
- a=0x00, b=0xFF accepted, rst_n pulled low 3 cycles into SCAN -> all outputs 0 immediately, in_ready=1, no out_valid pulse.
- WIDTH=1 instance, a=1, b=0 -> greater_than=1 after 1 cycle; a=1, b=1 -> equal_to=1 after 1 cycle.
